// File: rtl/microc_stk_if.sv
// Program-memory and control-unit signals of the microc_stk datapath.
// The slave modport is the datapath side; master is the control/memory side.
interface microc_stk_if #(
  parameter int AW = 10
);
  logic [15:0]   instr;
  logic [AW-1:0] pc;
  logic [5:0]    opcode;
  logic          z;
  logic          c;
  logic          s_inc;
  logic          s_inm;
  logic          we3;
  logic          wez;
  logic [2:0]    op;
  logic          s_call;
  logic          s_ret;
  logic          stk_ovf;
  logic          stk_unf;

  modport master (
    output instr, s_inc, s_inm, we3, wez, op, s_call, s_ret,
    input  pc, opcode, z, c, stk_ovf, stk_unf
  );

  modport slave (
    input  instr, s_inc, s_inm, we3, wez, op, s_call, s_ret,
    output pc, opcode, z, c, stk_ovf, stk_unf
  );
endinterface

// File: rtl/microc_stk.sv
// Single-cycle parametrised datapath with zero/carry flags and a hardware return stack.
// Defining MICROC_STK_RSTACK_EN enables the return stack and the stk_ovf/stk_unf sticky flags.
module microc_stk #(
  parameter int DW = 8,
  parameter int AW = 10,
  parameter int SD = 4
) (
  input logic         clk,
  input logic         reset,
  microc_stk_if.slave bus
);

  logic [3:0]    w_ra1;
  logic [3:0]    w_ra2;
  logic [3:0]    w_wa3;
  logic [DW-1:0] w_a;
  logic [DW-1:0] w_b;
  logic [DW-1:0] w_res;
  logic [DW-1:0] w_wd;
  logic [DW:0]   w_add;
  logic [DW:0]   w_sub;
  logic          w_carry;
  logic          w_zero;
  logic [DW-1:0] r_rf [16];
  logic          r_z;
  logic          r_c;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_pc_inc;
  logic [AW-1:0] w_target;
  logic [AW-1:0] w_pc_nxt;

  assign w_ra1 = bus.instr[11:8];
  assign w_ra2 = bus.instr[7:4];
  assign w_wa3 = bus.instr[3:0];

  // R0 is hard-wired to zero on both read ports.
  assign w_a = (w_ra1 == 4'd0) ? {DW{1'b0}} : r_rf[w_ra1];
  assign w_b = (w_ra2 == 4'd0) ? {DW{1'b0}} : r_rf[w_ra2];

  assign w_add = {1'b0, w_a} + {1'b0, w_b};
  assign w_sub = {1'b0, w_a} + {1'b0, ~w_b} + {{DW{1'b0}}, 1'b1};

  always_comb begin
    w_res   = {DW{1'b0}};
    w_carry = 1'b0;
    case (bus.op)
      3'b000: w_res = w_a;
      3'b001: w_res = ~w_a;
      3'b010: begin
        w_res   = w_add[DW-1:0];
        w_carry = w_add[DW];
      end
      3'b011: begin
        w_res   = w_sub[DW-1:0];
        w_carry = w_sub[DW];
      end
      3'b100: w_res = w_a & w_b;
      3'b101: w_res = w_a | w_b;
      3'b110: w_res = {DW{1'b0}} - w_a;
      3'b111: w_res = {DW{1'b0}} - w_b;
      default: begin
        w_res   = {DW{1'b0}};
        w_carry = 1'b0;
      end
    endcase
  end

  assign w_zero = (w_res == {DW{1'b0}});
  assign w_wd   = bus.s_inm ? DW'(bus.instr[7:0]) : w_res;

  // Register file contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (bus.we3 && (w_wa3 != 4'd0)) begin
      r_rf[w_wa3] <= w_wd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_z <= 1'b0;
      r_c <= 1'b0;
    end else if (bus.wez) begin
      r_z <= w_zero;
      r_c <= w_carry;
    end
  end

  assign w_pc_inc = r_pc + {{(AW-1){1'b0}}, 1'b1};
  assign w_target = bus.instr[AW-1:0];

`ifdef MICROC_STK_RSTACK_EN
  localparam int SPW = $clog2(SD + 1);
  localparam int IW  = $clog2(SD);

  logic [AW-1:0]  r_stk [SD];
  logic [SPW-1:0] r_sp;
  logic [SPW-1:0] w_top;
  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  logic           w_ovf_set;
  logic           w_unf_set;
  logic           r_ovf;
  logic           r_unf;

  assign w_full  = (r_sp == SPW'(SD));
  assign w_empty = (r_sp == {SPW{1'b0}});
  assign w_top   = r_sp - {{(SPW-1){1'b0}}, 1'b1};

  // Return outranks call; a call on a full stack still jumps but drops the push.
  always_comb begin
    w_pc_nxt  = w_pc_inc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    if (bus.s_ret) begin
      if (w_empty) begin
        w_pc_nxt  = w_pc_inc;
        w_unf_set = 1'b1;
      end else begin
        w_pc_nxt = r_stk[w_top[IW-1:0]];
        w_pop    = 1'b1;
      end
    end else if (bus.s_call) begin
      w_pc_nxt = w_target;
      if (w_full) begin
        w_ovf_set = 1'b1;
      end else begin
        w_push = 1'b1;
      end
    end else if (!bus.s_inc) begin
      w_pc_nxt = w_target;
    end else begin
      w_pc_nxt = w_pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stk[r_sp[IW-1:0]] <= w_pc_inc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sp  <= {SPW{1'b0}};
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_push) begin
        r_sp <= r_sp + {{(SPW-1){1'b0}}, 1'b1};
      end else if (w_pop) begin
        r_sp <= w_top;
      end
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end
      if (w_unf_set) begin
        r_unf <= 1'b1;
      end
    end
  end

  assign bus.stk_ovf = r_ovf;
  assign bus.stk_unf = r_unf;
`else
  logic w_unused_ret;
  assign w_unused_ret = bus.s_ret;

  // Without the stack a call is a plain jump and a return is ignored.
  always_comb begin
    w_pc_nxt = w_pc_inc;
    if (bus.s_call || !bus.s_inc) begin
      w_pc_nxt = w_target;
    end else begin
      w_pc_nxt = w_pc_inc;
    end
  end

  assign bus.stk_ovf = 1'b0;
  assign bus.stk_unf = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= {AW{1'b0}};
    end else begin
      r_pc <= w_pc_nxt;
    end
  end

  assign bus.pc     = r_pc;
  assign bus.opcode = bus.instr[15:10];
  assign bus.z      = r_z;
  assign bus.c      = r_c;

endmodule
